// File: rtl/mbus_layer_tx_sequencer_pkg.sv
// Shared widths, synchronizer depth and FSM state encoding for the layer TX sequencer.
// No logic; imported by the sequencer and its synchronizer.
package mbus_layer_tx_sequencer_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_REL,
    ST_WAIT_RESP,
    ST_RESP,
    ST_FIN
  } tx_state_t;

endpackage

// File: rtl/mbus_sync2.sv
// Multi-bit flop synchronizer for independent level signals; latency SYNC_STAGES cycles.
// No flow control: every bit is resampled each cycle.
module mbus_sync2
  import mbus_layer_tx_sequencer_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/mbus_layer_tx_sequencer.sv
// Buffers up to DEPTH words and sends them as one MBus message over the REQ/ACK handshake, retrying on FAIL.
// TX_REQ rises 1 cycle after START; each controller edge costs 2 sync cycles; writes/START ignored while BUSY.
module mbus_layer_tx_sequencer
  import mbus_layer_tx_sequencer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic [ADDR_WIDTH-1:0] MSG_ADDR,
  input  logic                  MSG_PRIORITY,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  FAIL_STAT,
  output logic [1:0]            RETRY_CNT,
  output logic [ADDR_WIDTH-1:0] TX_ADDR,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_REQ,
  output logic                  TX_PEND,
  output logic                  TX_PRIORITY,
  input  logic                  TX_ACK,
  input  logic                  TX_SUCC,
  input  logic                  TX_FAIL,
  output logic                  TX_RESP_ACK
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [1:0]    RETRY_MAX_C = 2'(MAX_RETRY);

  logic [DATA_WIDTH-1:0] msg_buf [DEPTH];

  tx_state_t             state, state_n;
  logic [CW-1:0]         count, count_n;
  logic [PW-1:0]         rd, rd_n;
  logic [1:0]            retry_cnt, retry_n;
  logic                  fail_stat, fail_stat_n;
  logic                  resp_fail, resp_fail_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic                  prio_q, prio_n;
  logic                  ack_s, succ_s, fail_s;
  logic                  wr_acc, start_acc, last_word, tx_active;

  mbus_sync2 #(.WIDTH(3)) u_sync (
    .clk   (CLK),
    .rst_n (RESETn),
    .d     ({TX_ACK, TX_SUCC, TX_FAIL}),
    .q     ({ack_s, succ_s, fail_s})
  );

  // A write in the START cycle counts towards the message, so START may see count 0 plus that write.
  assign wr_acc    = WR_EN && (state == ST_IDLE) && (count < DEPTH_C);
  assign start_acc = START && (state == ST_IDLE) && ((count != '0) || wr_acc);
  assign last_word = ({1'b0, rd} == (count - CW'(1)));
  assign tx_active = (state == ST_REQ) || (state == ST_REL);

  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      msg_buf[count[PW-1:0]] <= WR_DATA;
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    rd_n        = rd;
    retry_n     = retry_cnt;
    fail_stat_n = fail_stat;
    resp_fail_n = resp_fail;
    addr_n      = addr_q;
    prio_n      = prio_q;
    if (wr_acc) begin
      count_n = count + CW'(1);
    end
    case (state)
      ST_IDLE: begin
        if (start_acc) begin
          addr_n      = MSG_ADDR;
          prio_n      = MSG_PRIORITY;
          rd_n        = '0;
          retry_n     = '0;
          fail_stat_n = 1'b0;
          resp_fail_n = 1'b0;
          state_n     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (fail_s) begin
          resp_fail_n = 1'b1;
          state_n     = ST_RESP;
        end else if (ack_s) begin
          state_n = ST_REL;
        end
      end
      ST_REL: begin
        if (fail_s) begin
          resp_fail_n = 1'b1;
          state_n     = ST_RESP;
        end else if (!ack_s) begin
          if (!last_word) begin
            rd_n    = rd + PW'(1);
            state_n = ST_REQ;
          end else begin
            state_n = ST_WAIT_RESP;
          end
        end
      end
      ST_WAIT_RESP: begin
        // FAIL wins when both arrive together.
        if (fail_s) begin
          resp_fail_n = 1'b1;
          state_n     = ST_RESP;
        end else if (succ_s) begin
          resp_fail_n = 1'b0;
          state_n     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!succ_s && !fail_s && !ack_s) begin
          if (!resp_fail) begin
            state_n = ST_FIN;
          end else if (retry_cnt < RETRY_MAX_C) begin
            retry_n     = retry_cnt + 2'd1;
            rd_n        = '0;
            resp_fail_n = 1'b0;
            state_n     = ST_REQ;
          end else begin
            fail_stat_n = 1'b1;
            state_n     = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        count_n = '0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= ST_IDLE;
      count     <= '0;
      rd        <= '0;
      retry_cnt <= '0;
      fail_stat <= 1'b0;
      resp_fail <= 1'b0;
      addr_q    <= '0;
      prio_q    <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      rd        <= rd_n;
      retry_cnt <= retry_n;
      fail_stat <= fail_stat_n;
      resp_fail <= resp_fail_n;
      addr_q    <= addr_n;
      prio_q    <= prio_n;
    end
  end

  // REQ drops combinationally on an abort so the controller sees it without an extra cycle.
  assign TX_REQ      = (state == ST_REQ) && !fail_s;
  assign TX_DATA     = tx_active ? msg_buf[rd] : '0;
  assign TX_PEND     = tx_active && !last_word;
  assign TX_RESP_ACK = (state == ST_RESP);
  assign DONE        = (state == ST_FIN);
  assign BUSY        = (state != ST_IDLE);
  assign FAIL_STAT   = fail_stat;
  assign RETRY_CNT   = retry_cnt;
  assign TX_ADDR     = addr_q;
  assign TX_PRIORITY = prio_q;

endmodule

// File: tb/tb_mbus_layer_tx_sequencer.sv
// Directed and randomized bench acting as the MBus controller; a word-queue model predicts data, PEND and retry outcome.
module tb_mbus_layer_tx_sequencer;
  import mbus_layer_tx_sequencer_pkg::*;

  localparam int DEPTH     = 8;
  localparam int MAX_RETRY = 2;

  logic                  CLK = 1'b0;
  logic                  RESETn = 1'b0;
  logic [ADDR_WIDTH-1:0] MSG_ADDR = '0;
  logic                  MSG_PRIORITY = 1'b0;
  logic                  WR_EN = 1'b0;
  logic [DATA_WIDTH-1:0] WR_DATA = '0;
  logic                  START = 1'b0;
  logic                  BUSY, DONE, FAIL_STAT;
  logic [1:0]            RETRY_CNT;
  logic [ADDR_WIDTH-1:0] TX_ADDR;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK;
  logic                  TX_ACK = 1'b0;
  logic                  TX_SUCC = 1'b0;
  logic                  TX_FAIL = 1'b0;

  int total = 0;
  int bad = 0;
  logic [31:0] model_q[$];
  logic [ADDR_WIDTH-1:0] exp_addr;
  logic exp_prio;

  mbus_layer_tx_sequencer #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
    .CLK(CLK), .RESETn(RESETn), .MSG_ADDR(MSG_ADDR), .MSG_PRIORITY(MSG_PRIORITY),
    .WR_EN(WR_EN), .WR_DATA(WR_DATA), .START(START), .BUSY(BUSY), .DONE(DONE),
    .FAIL_STAT(FAIL_STAT), .RETRY_CNT(RETRY_CNT), .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA),
    .TX_REQ(TX_REQ), .TX_PEND(TX_PEND), .TX_PRIORITY(TX_PRIORITY), .TX_ACK(TX_ACK),
    .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL), .TX_RESP_ACK(TX_RESP_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return TX_REQ;
      1:       return TX_RESP_ACK;
      default: return DONE;
    endcase
  endfunction

  task automatic wait_sig(input int s, input logic v, input string tag);
    int n = 0;
    while (sig(s) !== v && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 64'(sig(s) === v), 64'd1);
  endtask

  // Model of the buffer: accepted only when idle, saturating at DEPTH words.
  task automatic wr(input logic [31:0] d);
    WR_EN = 1'b1;
    WR_DATA = d;
    tick();
    WR_EN = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(d);
  endtask

  task automatic start_msg(input logic [ADDR_WIDTH-1:0] a, input logic p, input bit with_wr, input logic [31:0] d);
    START = 1'b1;
    MSG_ADDR = a;
    MSG_PRIORITY = p;
    WR_EN = with_wr;
    WR_DATA = d;
    tick();
    START = 1'b0;
    WR_EN = 1'b0;
    exp_addr = a;
    exp_prio = p;
    if (with_wr && model_q.size() < DEPTH) model_q.push_back(d);
  endtask

  // Plays the controller for one message; fail_attempts leading attempts fail (by abort at abort_idx or FAIL response).
  task automatic run_msg(input int fail_attempts, input int abort_idx, input bit both);
    int n = model_q.size();
    int attempts = ((fail_attempts > MAX_RETRY) ? MAX_RETRY : fail_attempts) + 1;
    bit exp_fail = (fail_attempts > MAX_RETRY);
    for (int a = 0; a < attempts; a++) begin
      bit fail_this = (a < fail_attempts);
      bit aborted = 1'b0;
      for (int i = 0; i < n; i++) begin
        wait_sig(0, 1'b1, "req_rise");
        chk("tx_data", 64'(TX_DATA), 64'(model_q[i]));
        chk("tx_pend", 64'(TX_PEND), 64'(i < n - 1));
        if (i == 0) begin
          chk("tx_addr", 64'(TX_ADDR), 64'(exp_addr));
          chk("tx_prio", 64'(TX_PRIORITY), 64'(exp_prio));
          chk("busy_in_msg", 64'(BUSY), 64'd1);
        end
        if (fail_this && abort_idx == i) begin
          int c = 0;
          TX_FAIL = 1'b1;
          while (TX_REQ === 1'b1 && c < 4) begin
            tick();
            c++;
          end
          chk("abort_req_drop_within_3", 64'(c <= 3), 64'd1);
          aborted = 1'b1;
          break;
        end
        repeat ($urandom_range(0, 3)) tick();
        TX_ACK = 1'b1;
        wait_sig(0, 1'b0, "req_fall");
        repeat ($urandom_range(0, 3)) tick();
        TX_ACK = 1'b0;
        tick();
        chk("req_low_after_ack_fall", 64'(TX_REQ), 64'd0);
      end
      if (!aborted) begin
        repeat ($urandom_range(0, 3)) tick();
        if (fail_this) begin
          TX_FAIL = 1'b1;
          TX_SUCC = both;
        end else begin
          TX_SUCC = 1'b1;
        end
      end
      wait_sig(1, 1'b1, "resp_ack_rise");
      repeat ($urandom_range(0, 3)) tick();
      TX_SUCC = 1'b0;
      TX_FAIL = 1'b0;
      wait_sig(1, 1'b0, "resp_ack_fall");
      if (a == attempts - 1) begin
        chk("done_pulse", 64'(DONE), 64'd1);
        chk("fail_stat", 64'(FAIL_STAT), 64'(exp_fail));
        chk("retry_cnt", 64'(RETRY_CNT), 64'(attempts - 1));
        tick();
        chk("done_one_cycle", 64'(DONE), 64'd0);
        chk("busy_after_done", 64'(BUSY), 64'd0);
      end else begin
        chk("no_done_on_retry", 64'(DONE), 64'd0);
      end
    end
    model_q.delete();
  endtask

  task automatic expect_quiet(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (TX_REQ !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) seen = 1'b1;
      tick();
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_req", 64'(TX_REQ), 64'd0);
    chk("rst_resp_ack", 64'(TX_RESP_ACK), 64'd0);
    chk("rst_addr", 64'(TX_ADDR), 64'd0);
    chk("rst_data", 64'(TX_DATA), 64'd0);
    chk("rst_pend", 64'(TX_PEND), 64'd0);
    chk("rst_fail_stat", 64'(FAIL_STAT), 64'd0);
    chk("rst_retry", 64'(RETRY_CNT), 64'd0);
    RESETn = 1'b1;
    tick();

    // Single word, TX_REQ one cycle after START.
    wr(32'hDEADBEEF);
    start_msg(32'h0000_0012, 1'b0, 1'b0, 32'h0);
    chk("req_latency", 64'(TX_REQ), 64'd1);
    run_msg(0, -1, 1'b0);

    // Three words, last written together with START.
    wr(32'h1);
    wr(32'h2);
    start_msg($urandom(), 1'b1, 1'b1, 32'h3);
    run_msg(0, -1, 1'b0);

    // FAIL after last word once, then success.
    for (int i = 0; i < 3; i++) wr($urandom());
    start_msg($urandom(), 1'b0, 1'b0, 32'h0);
    run_msg(1, -1, 1'b0);

    // Abort during word 2 on every attempt.
    for (int i = 0; i < 3; i++) wr($urandom());
    start_msg($urandom(), 1'b1, 1'b0, 32'h0);
    run_msg(3, 1, 1'b0);

    // Randomized messages.
    for (int k = 0; k < 6; k++) begin
      int n = $urandom_range(1, DEPTH);
      int nf = $urandom_range(0, 3);
      int ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
      for (int i = 0; i < n; i++) wr($urandom());
      start_msg($urandom(), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
      run_msg(nf, ab, 1'($urandom_range(0, 1)));
    end

    // START with empty buffer.
    START = 1'b1;
    tick();
    START = 1'b0;
    expect_quiet("empty_start_ignored");

    // START and WR_EN while busy are ignored.
    wr(32'hA5A5_0001);
    wr(32'hA5A5_0002);
    start_msg($urandom(), 1'b0, 1'b0, 32'h0);
    START = 1'b1;
    WR_EN = 1'b1;
    WR_DATA = 32'hBAD0_BAD0;
    tick();
    START = 1'b0;
    WR_EN = 1'b0;
    run_msg(0, -1, 1'b0);
    START = 1'b1;
    tick();
    START = 1'b0;
    expect_quiet("busy_write_discarded");

    // DEPTH+1 writes saturate at DEPTH words.
    for (int i = 0; i <= DEPTH; i++) wr($urandom());
    chk("model_saturates", 64'(model_q.size()), 64'(DEPTH));
    start_msg($urandom(), 1'b1, 1'b0, 32'h0);
    run_msg(0, -1, 1'b0);

    // Reset while in REL of word 1.
    wr($urandom());
    wr($urandom());
    start_msg($urandom(), 1'b0, 1'b0, 32'h0);
    wait_sig(0, 1'b1, "rst_case_req");
    TX_ACK = 1'b1;
    wait_sig(0, 1'b0, "rst_case_rel");
    RESETn = 1'b0;
    #1;
    chk("midrst_req", 64'(TX_REQ), 64'd0);
    chk("midrst_resp_ack", 64'(TX_RESP_ACK), 64'd0);
    chk("midrst_busy", 64'(BUSY), 64'd0);
    TX_ACK = 1'b0;
    model_q.delete();
    repeat (2) tick();
    RESETn = 1'b1;
    tick();
    wr(32'hC0FFEE01);
    start_msg(32'h0000_0034, 1'b1, 1'b0, 32'h0);
    run_msg(0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mbus_layer_tx_sequencer.md
Name: mbus_layer_tx_sequencer

Overview:
Layer-side initiator that drives the MBus controller's TX handshake: TX_REQ, TX_ADDR, TX_DATA, TX_PEND and TX_PRIORITY out; TX_ACK, TX_SUCC and TX_FAIL in; TX_RESP_ACK out.
Local logic loads an address and up to DEPTH 32-bit words into an internal buffer, then pulses START.
The block sends the words as one multi-word MBus message using the 4-phase REQ/ACK protocol, collects the SUCC/FAIL response and retries automatically on failure.
It sits between layer application logic and mbus_ctrl_layer_wrapper / mbus_layer_wrapper.

Parameters:
DEPTH, 8, message buffer depth in words (power of 2, ≥2).
MAX_RETRY, 2, automatic resends after TX_FAIL (0 = no retry).

Ports:
CLK  in  1  layer clock
RESETn  in  1  asynchronous active-low reset
MSG_ADDR  in  `ADDR_WIDTH  destination address, sampled at START
MSG_PRIORITY  in  1  priority bit, sampled at START
WR_EN  in  1  write WR_DATA into buffer at write pointer
WR_DATA  in  `DATA_WIDTH  buffer write data
START  in  1  single-cycle start pulse
BUSY  out  1  high from accepted START until DONE
DONE  out  1  one-cycle completion pulse
FAIL_STAT  out  1  final result (1 = failed after retries); valid at DONE, held until next accepted START
RETRY_CNT  out  2  resends used for the last message
TX_ADDR  out  `ADDR_WIDTH  to controller
TX_DATA  out  `DATA_WIDTH  to controller
TX_REQ  out  1  to controller
TX_PEND  out  1  to controller; 1 = more words follow
TX_PRIORITY  out  1  to controller
TX_ACK  in  1  from controller (asynchronous)
TX_SUCC  in  1  from controller (asynchronous)
TX_FAIL  in  1  from controller (asynchronous)
TX_RESP_ACK  out  1  to controller

Behaviour:
- Reset values: all outputs 0. Write pointer, read pointer, word count, retry count and FSM are cleared (FSM = IDLE).
- Reset mid-message drops TX_REQ and TX_RESP_ACK immediately. The buffer is discarded.
- TX_ACK, TX_SUCC and TX_FAIL each pass through a 2-flop synchronizer (ack_s, succ_s, fail_s). All FSM decisions use the synchronized values.
- Buffer writes:
  - Accepted only in IDLE, and only while count < DEPTH. Otherwise ignored silently.
  - Each accepted write stores the word and increments count (width log2(DEPTH)+1).
- START:
  - Accepted only in IDLE with count ≥ 1. START with count = 0, or while BUSY, is ignored: no DONE, no state change.
  - WR_EN together with START in the same cycle: the write is accepted first and is included in the message.
  - On acceptance: latch MSG_ADDR and MSG_PRIORITY into TX_ADDR and TX_PRIORITY, set read index to 0, RETRY_CNT ← 0, FAIL_STAT ← 0, BUSY ← 1.
- FSM states: IDLE, REQ, REL, WAIT_RESP, RESP, FIN.
- IDLE → REQ: the cycle after START is accepted.
- REQ:
  - TX_REQ = 1, TX_DATA = buf[rd], TX_PEND = (rd ≠ count−1).
  - On ack_s = 1 → REL.
- REL:
  - TX_REQ = 0. TX_DATA and TX_PEND are held.
  - When ack_s = 0: if TX_PEND was 1, increment rd and go to REQ; otherwise go to WAIT_RESP.
- fail_s = 1 in REQ or REL (bus abort, e.g. arbitration loss or NAK): drop TX_REQ the same cycle and go to RESP.
- WAIT_RESP: wait for succ_s or fail_s, then go to RESP and latch which one occurred.
- RESP:
  - TX_RESP_ACK = 1.
  - Leave when succ_s = 0, fail_s = 0 and ack_s = 0; deassert TX_RESP_ACK on exit.
  - If the result was success → FIN.
  - If fail and RETRY_CNT < MAX_RETRY: RETRY_CNT + 1, rd ← 0, → REQ.
  - Otherwise FAIL_STAT ← 1 → FIN.
- FIN: DONE = 1 for one cycle, BUSY ← 0, count ← 0, write pointer ← 0, → IDLE.
- Simultaneous succ_s and fail_s: treated as fail.
- Minimum handshake latency: TX_REQ rises 1 cycle after START. Each synchronized edge adds 2 cycles.

Decomposition:
- Add FSM state localparams and a SYNC_STAGES constant (2) to include/mbus_def.v alongside ADDR_WIDTH and DATA_WIDTH.
- One sub-module, mbus_sync2: parameterizable-width 2-flop synchronizer with async active-low reset, instantiated once for {TX_ACK, TX_SUCC, TX_FAIL}.
- The buffer is an inline register array.

Test Plan:
- Single word: write 0xDEADBEEF, MSG_ADDR = 0x00012, START; bench ACKs, then raises SUCC → TX_DATA = 0xDEADBEEF, TX_PEND = 0, TX_RESP_ACK handshake completes, DONE pulse, FAIL_STAT = 0, RETRY_CNT = 0.
- Three words 0x1, 0x2, 0x3 → three REQ/ACK cycles with TX_PEND = 1, 1, 0 and data in order; TX_REQ never rises while TX_ACK is high; SUCC → DONE.
- FAIL after the last word with MAX_RETRY = 2 → message resent from word 0; SUCC on the 2nd attempt → RETRY_CNT = 1, FAIL_STAT = 0.
- FAIL asserted during REQ of word 2 on every attempt → TX_REQ drops within 3 cycles; after 3 attempts DONE with FAIL_STAT = 1, RETRY_CNT = 2.
- START with an empty buffer, START while BUSY, and WR_EN while BUSY → no DONE, no TX_REQ, buffer unchanged; DEPTH+1 writes → count saturates at DEPTH.
- RESETn asserted while in REL of word 1 → TX_REQ, TX_RESP_ACK, BUSY = 0 immediately; after release a new 1-word message completes normally.
